// File: rtl/paula_floppy_dma_reader_pkg.sv
// ==== paula_floppy_dma_reader_pkg : shared constants for the Paula disk DMA read drain ====
// ==== rev 1.0 ====
`default_nettype none

package paula_floppy_dma_reader_pkg;

  localparam int LEN_W_DEFAULT = 14;

  // DSKLEN register bit positions
  localparam int DMAEN_BIT = 15;
  localparam int WRITE_BIT = 14;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_SYNC  = 2'd1;
  localparam logic [ST_W-1:0] ST_FETCH = 2'd2;
  localparam logic [ST_W-1:0] ST_REQ   = 2'd3;

  function automatic logic [ST_W-1:0] start_state(input logic wordsync);
    return wordsync ? ST_SYNC : ST_FETCH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/paula_floppy_fifo_pop.sv
// ==== paula_floppy_fifo_pop : FIFO pop sequencer with one-enable gap after every pop ====
// ==== rev 1.0 ====
`default_nettype none

module paula_floppy_fifo_pop (
  input  logic clk,
  input  logic reset,
  input  logic clk7_en,
  input  logic fifo_empty,
  input  logic want_pop,
  output logic word_valid,
  output logic fifo_rd
);

  logic popped_last;

  // The head is stale for one enable cycle after a pop (RAM output latency).
  assign word_valid = !fifo_empty && !popped_last;
  assign fifo_rd    = want_pop && word_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      popped_last <= 1'b0;
    end else if (clk7_en) begin
      popped_last <= fifo_rd;
    end
  end

endmodule

`default_nettype wire

// File: rtl/paula_floppy_dma_reader.sv
// ==== paula_floppy_dma_reader : drains floppy FIFO words to the disk DMA slot (read direction) ====
// ==== rev 1.0 ====
`default_nettype none

module paula_floppy_dma_reader
  import paula_floppy_dma_reader_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk7_en,
  input  logic [15:0]      fifo_out,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic             dsklen_wr,
  input  logic [15:0]      dsklen,
  input  logic [15:0]      dsksync,
  input  logic             wordsync,
  output logic             dma_req,
  output logic [15:0]      dma_data,
  input  logic             dma_ack,
  output logic             int_dsksyn,
  output logic             int_dskblk,
  output logic             busy,
  output logic [LEN_W-1:0] words_left
);

  logic [ST_W-1:0]  state;
  logic             armed;
  logic             word_valid;
  logic             want_pop;
  logic [LEN_W-1:0] load_len;

  assign load_len = dsklen[LEN_W-1:0];

  // A DSKLEN write overrides the sequencer this cycle, so never pop under it.
  assign want_pop = ((state == ST_SYNC) || (state == ST_FETCH)) && !dsklen_wr;

  paula_floppy_fifo_pop u_pop (
    .clk        (clk),
    .reset      (reset),
    .clk7_en    (clk7_en),
    .fifo_empty (fifo_empty),
    .want_pop   (want_pop),
    .word_valid (word_valid),
    .fifo_rd    (fifo_rd)
  );

  assign dma_req = (state == ST_REQ);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      armed      <= 1'b0;
      words_left <= '0;
      dma_data   <= 16'h0000;
      int_dsksyn <= 1'b0;
      int_dskblk <= 1'b0;
    end else if (clk7_en) begin
      int_dsksyn <= 1'b0;
      int_dskblk <= 1'b0;
      if (dsklen_wr) begin
        if (!dsklen[DMAEN_BIT]) begin
          armed <= 1'b0;
          state <= ST_IDLE;
        end else if (!armed) begin
          armed <= 1'b1;
        end else if (dsklen[WRITE_BIT]) begin
          state <= ST_IDLE;
        end else begin
          words_left <= load_len;
          if (load_len == '0) begin
            int_dskblk <= 1'b1;
            armed      <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            state <= start_state(wordsync);
          end
        end
      end else begin
        case (state)
          ST_SYNC: begin
            // Sync word is consumed here and never reaches the DMA slot.
            if (fifo_rd && (fifo_out == dsksync)) begin
              int_dsksyn <= 1'b1;
              state      <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (fifo_rd) begin
              dma_data   <= fifo_out;
              int_dsksyn <= (fifo_out == dsksync);
              state      <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (dma_ack) begin
              words_left <= words_left - LEN_W'(1);
              if (words_left == LEN_W'(1)) begin
                int_dskblk <= 1'b1;
                armed      <= 1'b0;
                state      <= ST_IDLE;
              end else begin
                state <= ST_FETCH;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_paula_floppy_dma_reader.sv
// ==== tb_paula_floppy_dma_reader : self-checking bench, behavioural model plus FIFO environment ====
// ==== rev 1.0 ====
`default_nettype none

module tb_paula_floppy_dma_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk7_en;
  logic [15:0] fifo_out;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        dsklen_wr;
  logic [15:0] dsklen;
  logic [15:0] dsksync;
  logic        wordsync;
  logic        dma_req;
  logic [15:0] dma_data;
  logic        dma_ack;
  logic        int_dsksyn;
  logic        int_dskblk;
  logic        busy;
  logic [13:0] words_left;

  always #5 clk = ~clk;

  paula_floppy_dma_reader #(.LEN_W(14)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk7_en    (clk7_en),
    .fifo_out   (fifo_out),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .dsklen_wr  (dsklen_wr),
    .dsklen     (dsklen),
    .dsksync    (dsksync),
    .wordsync   (wordsync),
    .dma_req    (dma_req),
    .dma_data   (dma_data),
    .dma_ack    (dma_ack),
    .int_dsksyn (int_dsksyn),
    .int_dskblk (int_dskblk),
    .busy       (busy),
    .words_left (words_left)
  );

  typedef enum int {M_IDLE, M_SEARCH, M_WAITWORD, M_OFFER} mphase_t;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model
  mphase_t     m_phase;
  bit          m_armed;
  logic [13:0] m_left;
  logic [15:0] m_word;
  bit          m_popped;
  bit          m_syn, m_blk;

  // FIFO environment: registered head view lags the queue by one enable
  logic [15:0] fq[$];
  logic [15:0] pend[$];
  logic [15:0] got[$];
  logic        f_empty;
  logic [15:0] f_out;

  bit          en, wr, ack_auto, ack_force;
  logic [15:0] len;
  int          ack_lat, req_age;
  int          rd_cnt, syn_cnt, blk_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_armed = 0; m_left = 0; m_word = 0;
    m_popped = 0; m_syn = 0; m_blk = 0; req_age = 0;
  endtask

  task automatic model_step(input bit valid, input bit rd, input bit a);
    m_syn = 0; m_blk = 0;
    if (wr) begin
      if (!len[15]) begin
        m_armed = 0; m_phase = M_IDLE;
      end else if (!m_armed) begin
        m_armed = 1;
      end else if (len[14]) begin
        m_phase = M_IDLE;
      end else begin
        m_left = len[13:0];
        if (m_left == 0) begin
          m_blk = 1; m_armed = 0; m_phase = M_IDLE;
        end else begin
          m_phase = wordsync ? M_SEARCH : M_WAITWORD;
        end
      end
    end else begin
      case (m_phase)
        M_SEARCH:   if (valid && f_out == dsksync) begin m_syn = 1; m_phase = M_WAITWORD; end
        M_WAITWORD: if (valid) begin m_word = f_out; m_syn = (f_out == dsksync); m_phase = M_OFFER; end
        M_OFFER:    if (a) begin
                      m_left = m_left - 1;
                      if (m_left == 0) begin m_blk = 1; m_armed = 0; m_phase = M_IDLE; end
                      else m_phase = M_WAITWORD;
                    end
        default: ;
      endcase
    end
    m_popped = rd;
  endtask

  task automatic cycle();
    bit valid, exp_rd, exp_req, a, nempty;
    logic [15:0] nout;
    valid   = !f_empty && !m_popped;
    exp_req = (m_phase == M_OFFER);
    exp_rd  = (m_phase == M_SEARCH || m_phase == M_WAITWORD) && valid && !wr;
    a       = ack_force || (ack_auto && exp_req && req_age >= ack_lat);
    clk7_en = en; dsklen_wr = wr; dsklen = len; dma_ack = a;
    fifo_empty = f_empty; fifo_out = f_out;
    #1;
    chk("fifo_rd", fifo_rd, exp_rd);
    chk("dma_req", dma_req, exp_req);
    chk("busy", busy, m_phase != M_IDLE);
    chk("words_left", words_left, m_left);
    chk("int_dsksyn", int_dsksyn, m_syn);
    chk("int_dskblk", int_dskblk, m_blk);
    if (exp_req) chk("dma_data", dma_data, m_word);
    if (en) begin
      if (fifo_rd) rd_cnt++;
      if (int_dsksyn) syn_cnt++;
      if (int_dskblk) blk_cnt++;
      if (exp_req && a && !wr) got.push_back(m_word);
      req_age = exp_req ? req_age + 1 : 0;
      model_step(valid, exp_rd, a);
      nempty = (fq.size() == 0);
      nout   = (fq.size() > 0) ? fq[0] : f_out;
      if (fifo_rd && fq.size() > 0) fq.delete(0);
      while (pend.size() > 0) fq.push_back(pend.pop_front());
      f_out = nout; f_empty = nempty;
    end
    @(negedge clk);
    wr = 0; ack_force = 0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr_len(input logic [15:0] v);
    wr = 1; len = v; cycle();
  endtask

  task automatic flush();
    fq.delete(); pend.delete(); f_empty = 1; f_out = 16'h0000;
  endtask

  task automatic wait_req(input string nm);
    int k = 0;
    while (!dma_req && k < 30) begin cycle(); k++; end
    chk(nm, dma_req, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; en = 1; wr = 0; len = 0; ack_auto = 0; ack_force = 0; ack_lat = 2;
    dsksync = 16'h4489; wordsync = 0; f_empty = 1; f_out = 0;
    clk7_en = 1; dsklen_wr = 0; dsklen = 0; dma_ack = 0; fifo_empty = 1; fifo_out = 0;
    rd_cnt = 0; syn_cnt = 0; blk_cnt = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_req", dma_req, 0);
    chk("reset_rd", fifo_rd, 0);
    chk("reset_left", words_left, 0);
    chk("reset_data", dma_data, 0);
    chk("reset_ints", {int_dsksyn, int_dskblk}, 0);
    reset = 0;

    // single arm only
    wr_len(16'h0000); rd_cnt = 0;
    wr_len(16'h8004);
    pend = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    run(12);
    chk("arm_rd_count", rd_cnt, 0);
    chk("arm_busy", busy, 0);

    // normal read
    wr_len(16'h0000); flush(); run(2);
    pend = '{16'hA001, 16'hA002, 16'hA003}; run(3);
    got.delete(); blk_cnt = 0; ack_auto = 1; ack_lat = 2;
    wr_len(16'h8003); wr_len(16'h8003);
    chk("norm_start_left", words_left, 3);
    run(30);
    chk("norm_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("norm_w0", got[0], 16'hA001);
      chk("norm_w1", got[1], 16'hA002);
      chk("norm_w2", got[2], 16'hA003);
    end
    chk("norm_blk", blk_cnt, 1);
    chk("norm_fifo_empty", fq.size(), 0);
    chk("norm_busy", busy, 0);

    // sync search
    wr_len(16'h0000); flush(); wordsync = 1;
    pend = '{16'hAAAA, 16'h4489, 16'h1234, 16'h5678}; run(3);
    got.delete(); syn_cnt = 0; blk_cnt = 0;
    wr_len(16'h8002); wr_len(16'h8002);
    run(30);
    chk("sync_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("sync_w0", got[0], 16'h1234);
      chk("sync_w1", got[1], 16'h5678);
    end
    chk("sync_syn", syn_cnt, 1);
    chk("sync_blk", blk_cnt, 1);
    wordsync = 0;

    // underflow
    wr_len(16'h0000); flush(); pend = '{16'hB001}; run(3);
    got.delete(); rd_cnt = 0; blk_cnt = 0;
    wr_len(16'h8003); wr_len(16'h8003);
    run(25);
    chk("uf_count", got.size(), 1);
    chk("uf_rd", rd_cnt, 1);
    chk("uf_left", words_left, 2);
    chk("uf_busy", busy, 1);
    pend = '{16'hB002, 16'hB003};
    run(30);
    chk("uf_count2", got.size(), 3);
    chk("uf_blk", blk_cnt, 1);

    // abort mid-REQ
    wr_len(16'h0000); flush(); ack_auto = 0;
    pend = '{16'hC001, 16'hC002, 16'hC003}; run(3); blk_cnt = 0;
    wr_len(16'h8005); wr_len(16'h8005);
    wait_req("abort_req_seen");
    wr_len(16'h0000);
    chk("abort_req", dma_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_left", words_left, 5);
    run(5);
    chk("abort_blk", blk_cnt, 0);

    // abort coincident with ack
    flush(); pend = '{16'hD001, 16'hD002}; run(3);
    wr_len(16'h8002); wr_len(16'h8002);
    wait_req("abort_ack_req_seen");
    wr = 1; len = 16'h0000; ack_force = 1; cycle();
    chk("abort_ack_left", words_left, 2);
    chk("abort_ack_req", dma_req, 0);
    run(3);
    chk("abort_ack_blk", blk_cnt, 0);

    // zero length
    flush(); wr_len(16'h0000); pend = '{16'hE001}; run(3);
    rd_cnt = 0; blk_cnt = 0;
    wr_len(16'h8000); wr_len(16'h8000);
    chk("zero_blk_now", int_dskblk, 1);
    run(5);
    chk("zero_blk", blk_cnt, 1);
    chk("zero_rd", rd_cnt, 0);

    // clock-enable gating across an ack
    flush(); wr_len(16'h0000); pend = '{16'hF001}; run(3);
    wr_len(16'h8001); wr_len(16'h8001);
    wait_req("gate_req_seen");
    en = 0;
    repeat (4) begin ack_force = 1; cycle(); end
    chk("gate_req", dma_req, 1);
    chk("gate_left", words_left, 1);
    en = 1; blk_cnt = 0; ack_auto = 1;
    run(10);
    chk("gate_blk", blk_cnt, 1);

    // asynchronous reset mid-transfer
    flush(); wr_len(16'h0000); ack_auto = 0;
    pend = '{16'h0101, 16'h0202, 16'h0303}; run(3);
    wr_len(16'h8003); wr_len(16'h8003);
    wait_req("rst_req_seen");
    #2 reset = 1;
    #1;
    chk("rst_req", dma_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_left", words_left, 0);
    chk("rst_data", dma_data, 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    run(3);

    // randomized traffic
    flush(); wr_len(16'h0000); ack_auto = 1;
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom % 5) != 0;
      ack_lat = $urandom % 4;
      ack_force = ($urandom % 12) == 0;
      if (($urandom % 4) == 0 && (fq.size() + pend.size()) < 8)
        pend.push_back((($urandom % 3) == 0) ? dsksync : 16'($urandom));
      if (($urandom % 40) == 0) begin
        wr = 1;
        case ($urandom % 6)
          0:       len = 16'h0000;
          1:       len = 16'hC000 | 16'($urandom % 8);
          default: len = 16'h8000 | 16'($urandom % 7);
        endcase
      end
      if (($urandom % 40) == 0 && m_phase == M_IDLE) wordsync = 1'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/paula_floppy_dma_reader.md
Name: paula_floppy_dma_reader

Overview:
- Drain side of the floppy word FIFO. Pops 16-bit MFM words from the FIFO head and presents them to the Agnus disk DMA slot through a req/ack handshake.
- Implements the Paula DSKLEN double-write arm, DSKSYNC word search, length countdown, and the DSKSYN/DSKBLK interrupt pulses.
- Sits between the floppy FIFO and the disk DMA/register logic in Paula; read direction only.

Parameters:
LEN_W, 14, width of the DSKLEN word count field.

Ports:
clk  in  1  bus clock
reset  in  1  asynchronous, active-high reset
clk7_en  in  1  clock enable; all state advances only when high
fifo_out  in  16  FIFO head word
fifo_empty  in  1  FIFO empty flag (registered, one enable late)
fifo_rd  out  1  pop FIFO head; one enable-cycle pulse
dsklen_wr  in  1  DSKLEN register write strobe
dsklen  in  16  [15]=DMAEN, [14]=WRITE, [13:0]=word count
dsksync  in  16  sync word value
wordsync  in  1  ADKCON WORDSYNC: wait for sync before transfer
dma_req  out  1  word ready for DMA
dma_data  out  16  word being transferred
dma_ack  in  1  DMA slot consumed dma_data
int_dsksyn  out  1  one-cycle pulse on sync match
int_dskblk  out  1  one-cycle pulse on block done
busy  out  1  transfer active (state not IDLE)
words_left  out  LEN_W  remaining word count

Behaviour:
- Reset: all outputs 0; state IDLE; armed=0; hold register 0.
- All register updates are qualified by clk7_en. Pulse outputs last exactly one enable cycle.
- Arm logic on dsklen_wr:
  - DMAEN=0: clear armed. Abort any active state to IDLE the same cycle, drop dma_req, no interrupt.
  - DMAEN=1 with armed=0: set armed only.
  - DMAEN=1 with armed=1 and WRITE=0: load words_left=dsklen[13:0] and start.
  - DMAEN=1 with WRITE=1: no transfer; state stays or returns IDLE.
- Start with count 0: pulse int_dskblk the next enable cycle, return to IDLE, clear armed.
- Start target: SYNC if wordsync=1, else FETCH.
- Word valid rule: fifo_out is valid when fifo_empty=0 and fifo_rd was not asserted in the previous enable cycle. The gap after each pop covers FIFO RAM output latency.
- States:
  - IDLE: fifo_rd=0, dma_req=0.
  - SYNC: on a valid word, pop it. If it equals dsksync, pulse int_dsksyn and go to FETCH. The sync word itself is discarded, never transferred.
  - FETCH: on a valid word, capture it into dma_data, pop it, go to REQ. If the captured word equals dsksync, also pulse int_dsksyn; the word is still transferred.
  - REQ: dma_req=1 with dma_data stable. On dma_ack: dma_req=0 next cycle and decrement words_left.
    - If the new count is 0: pulse int_dskblk, clear armed, go to IDLE.
    - Otherwise go to FETCH.
- dma_ack outside REQ is ignored.
- FIFO empty during SYNC/FETCH: wait indefinitely with no pop. No underflow pop is ever issued.
- A DSKLEN write with DMAEN=0 in the same cycle as dma_ack: the abort wins; words_left is not decremented and no interrupt fires.
- Asynchronous reset mid-transfer: immediate return to reset values; the FIFO word in hold is lost.
- Maximum throughput is one word per 2 enable cycles plus the ack latency.

Decomposition:
- Shared package: state encoding (IDLE, SYNC, FETCH, REQ), DSKLEN bit positions (DMAEN=15, WRITE=14), LEN_W default.
- No sub-module needed. The FIFO pop/valid gap tracker may be factored into paula_floppy_fifo_pop, a small pop sequencer.

Test Plan:
- Single arm: write 0x8004 once, fill the FIFO with 4 words -> no fifo_rd, dma_req stays 0, busy=0.
- Normal read: write 0x8003 twice, wordsync=0, FIFO holds A1,A2,A3, ack each req after 2 cycles -> dma_data sequence A1,A2,A3; words_left 3→2→1→0; int_dskblk pulses once after the third ack; busy=0; FIFO empty.
- Sync search: dsksync=0x4489, wordsync=1, FIFO holds 0xAAAA,0x4489,0x1234,0x5678, len=2 -> first two words discarded, int_dsksyn pulses once, dma_data 0x1234 then 0x5678, int_dskblk pulses.
- Underflow: len=3, FIFO holds 1 word -> one transfer, then no fifo_rd while empty. Push 2 more words -> transfer resumes, block completes.
- Abort: mid-REQ, write 0x0000 -> dma_req low the next enable cycle, state IDLE, no int_dskblk, words_left frozen.
- Zero length and gating: write 0x8000 twice -> int_dskblk pulse, no fifo_rd. Hold clk7_en low across an ack -> no state change.
